// File: rtl/fazyrv_mem_resp_if.sv
// Strobe/ack bus between the core's imem/dmem ports and the memory responder.
// Optional feature macro: MEM_RESP_ERR_EN adds per-port error strobes.
interface fazyrv_mem_resp_if;
  logic        imem_stb_i;
  logic [31:0] imem_adr_i;
  logic [31:0] imem_dat_o;
  logic        imem_ack_o;
  logic        dmem_stb_i;
  logic        dmem_we_i;
  logic [3:0]  dmem_be_i;
  logic [31:0] dmem_adr_i;
  logic [31:0] dmem_dat_i;
  logic [31:0] dmem_dat_o;
  logic        dmem_ack_o;
`ifdef MEM_RESP_ERR_EN
  logic        imem_err_o;
  logic        dmem_err_o;

  modport master (
    output imem_stb_i, imem_adr_i, dmem_stb_i, dmem_we_i, dmem_be_i, dmem_adr_i, dmem_dat_i,
    input  imem_dat_o, imem_ack_o, dmem_dat_o, dmem_ack_o, imem_err_o, dmem_err_o
  );
  modport slave (
    input  imem_stb_i, imem_adr_i, dmem_stb_i, dmem_we_i, dmem_be_i, dmem_adr_i, dmem_dat_i,
    output imem_dat_o, imem_ack_o, dmem_dat_o, dmem_ack_o, imem_err_o, dmem_err_o
  );
`else
  modport master (
    output imem_stb_i, imem_adr_i, dmem_stb_i, dmem_we_i, dmem_be_i, dmem_adr_i, dmem_dat_i,
    input  imem_dat_o, imem_ack_o, dmem_dat_o, dmem_ack_o
  );
  modport slave (
    input  imem_stb_i, imem_adr_i, dmem_stb_i, dmem_we_i, dmem_be_i, dmem_adr_i, dmem_dat_i,
    output imem_dat_o, imem_ack_o, dmem_dat_o, dmem_ack_o
  );
`endif
endinterface

// File: rtl/fazyrv_mem_resp.sv
// Shared-RAM responder for the imem/dmem strobe/ack ports. dmem wins conflicts;
// each access completes LATENCY cycles after its strobe is sampled.
// Optional feature macro: MEM_RESP_ERR_EN turns out-of-range accesses into err pulses.
module fazyrv_mem_resp #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            rst_in,
  fazyrv_mem_resp_if.slave bus
);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                sel_d, sel_d_next;
  logic [ADDR_W-1:0]   word, word_next;
  logic                oor, oor_next;

  logic [31:0]         req_adr;
  logic [ADDR_W-1:0]   req_word;
  logic                req_oor;
  logic                sel_stb;
  logic                fire, fire_d, fire_oor, mem_we;
  logic [ADDR_W-1:0]   fire_word;
  logic [31:0]         rd_word;

  logic                imem_ack, dmem_ack, imem_err, dmem_err;
  logic [31:0]         imem_dat, dmem_dat;

  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  logic                unused_adr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

  assign req_adr  = bus.dmem_stb_i ? bus.dmem_adr_i : bus.imem_adr_i;
  assign req_word = req_adr[ADDR_W+1:2];
`ifdef MEM_RESP_ERR_EN
  assign req_oor  = |req_adr[31:ADDR_W+2];
`else
  assign req_oor  = 1'b0;
`endif
  assign sel_stb  = sel_d ? bus.dmem_stb_i : bus.imem_stb_i;
  assign rd_word  = mem[fire_word];
  // Writes are gated by reset so an access racing reset never lands in RAM.
  assign mem_we   = fire && fire_d && bus.dmem_we_i && !fire_oor && rst_in;

  assign unused_adr_bits = ^{bus.imem_adr_i, bus.dmem_adr_i};

  // Arbitration, latency countdown and the edge on which an access completes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sel_d_next = sel_d;
    word_next  = word;
    oor_next   = oor;
    fire       = 1'b0;
    fire_d     = sel_d;
    fire_word  = word;
    fire_oor   = oor;
    case (state)
      IDLE: begin
        if (bus.dmem_stb_i || bus.imem_stb_i) begin
          sel_d_next = bus.dmem_stb_i;
          word_next  = req_word;
          oor_next   = req_oor;
          if (LATENCY == 1) begin
            fire       = 1'b1;
            fire_d     = bus.dmem_stb_i;
            fire_word  = req_word;
            fire_oor   = req_oor;
            state_next = ACK;
          end else begin
            cnt_next   = CNT_W'(LATENCY - 1);
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!sel_stb) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt <= CNT_W'(1)) begin
          fire       = 1'b1;
          cnt_next   = '0;
          state_next = ACK;
        end else begin
          cnt_next   = cnt - CNT_W'(1);
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cnt   <= '0;
      sel_d <= 1'b0;
      word  <= '0;
      oor   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sel_d <= sel_d_next;
      word  <= word_next;
      oor   <= oor_next;
    end
  end

  // Registered completion strobes and read data; data holds between acks.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      imem_ack <= 1'b0;
      dmem_ack <= 1'b0;
      imem_err <= 1'b0;
      dmem_err <= 1'b0;
      imem_dat <= '0;
      dmem_dat <= '0;
    end else begin
      imem_ack <= fire && !fire_d && !fire_oor;
      dmem_ack <= fire &&  fire_d && !fire_oor;
      imem_err <= fire && !fire_d &&  fire_oor;
      dmem_err <= fire &&  fire_d &&  fire_oor;
      if (fire && fire_d)  dmem_dat <= fire_oor ? '0 : rd_word;
      if (fire && !fire_d) imem_dat <= fire_oor ? '0 : rd_word;
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[fire_word] <= merge_bytes(rd_word, bus.dmem_dat_i, bus.dmem_be_i);
  end

  assign bus.imem_ack_o = imem_ack;
  assign bus.dmem_ack_o = dmem_ack;
  assign bus.imem_dat_o = imem_dat;
  assign bus.dmem_dat_o = dmem_dat;
`ifdef MEM_RESP_ERR_EN
  assign bus.imem_err_o = imem_err;
  assign bus.dmem_err_o = dmem_err;
`else
  logic unused_err;
  assign unused_err = imem_err ^ dmem_err;
`endif
endmodule
